// File: rtl/tron_score_pkg.sv
// Shared encodings for the Tron round/score tracker.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package tron_score_pkg;

    // Top-level game-state encodings driven by the game-state controller.
    localparam logic [2:0] GS_MENU = 3'd1;
    localparam logic [2:0] GS_PLAY = 3'd2;

    // Round/score FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } sb_state_t;

endpackage

// File: rtl/score_counter.sv
// Saturating per-player score counter with synchronous clear and increment enable.
// Latency: count updates on the clock edge after inc/clr; clr wins over inc.
// Backpressure: none; increments at the ceiling are silently dropped.
module score_counter #(
    parameter int SCORE_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] count
);

    localparam logic [SCORE_W-1:0] MAX_COUNT = '1;

    // Count up on inc, stick at the ceiling, clear on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/round_scoreboard.sv
// N-player Tron round/score tracker: crash edge detect, survivor scoring, round hold, match winner.
// Latency: score at t+1 after a crash rise, winner/match_over at t+2, reset_round at t+2 (+HOLD_CYCLES with ROUND_HOLD_EN).
// Backpressure: none; rises outside PLAY or after the first one in a round are ignored.
module round_scoreboard
    import tron_score_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 2,
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic [2:0]                     Game_State,
    input  logic [NUM_PLAYERS-1:0]         crash,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           reset_round,
    output logic                           round_active,
    output logic [NUM_PLAYERS-1:0]         winner,
    output logic                           match_over
);

    localparam logic [SCORE_W-1:0] WIN_VALUE = SCORE_W'(WIN_SCORE);

    // Reject parameter sets the scoring logic cannot represent.
    if ((NUM_PLAYERS < 2) || (NUM_PLAYERS > 4) || (WIN_SCORE < 1) ||
        (WIN_SCORE > ((1 << SCORE_W) - 1)) || (HOLD_CYCLES < 1)) begin : g_param_check
        $error("round_scoreboard: illegal parameter combination");
    end

    sb_state_t              state;
    sb_state_t              state_nxt;
    logic [NUM_PLAYERS-1:0] crash_q;
    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] win_mask;
    logic [NUM_PLAYERS-1:0] score_inc;
    logic                   menu;
    logic                   gs_play;
    logic                   any_rise;
    logic                   all_crash;
    logic                   round_end;
    logic                   award;
    logic                   any_win;
    logic                   hold_first;
    logic                   rr_nxt;
    logic                   win_set;

`ifdef ROUND_HOLD_EN
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              cnt_load;
`endif

    assign menu      = (Game_State == GS_MENU);
    assign gs_play   = (Game_State == GS_PLAY);
    assign rise      = crash & ~crash_q;
    assign any_rise  = |rise;
    assign all_crash = &crash;

    // First rise of the round ends it; a simultaneous all-player crash is a draw.
    assign round_end = !menu && (state == PLAY) && any_rise;
    assign award     = round_end && !all_crash;
    assign score_inc = award ? ~crash : '0;

    assign round_active = (state == PLAY);
    assign match_over   = (state == OVER);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            score_counter #(
                .SCORE_W (SCORE_W)
            ) u_score (
                .clk   (Clk),
                .rst_n (Reset_n),
                .clr   (menu),
                .inc   (score_inc[gi]),
                .count (score[gi*SCORE_W +: SCORE_W])
            );

            assign win_mask[gi] = (score[gi*SCORE_W +: SCORE_W] >= WIN_VALUE);
        end
    endgenerate

    assign any_win = |win_mask;

    // Next-state, reset_round request and winner latch decision.
    always_comb begin
        state_nxt = state;
        rr_nxt    = 1'b0;
        win_set   = 1'b0;
`ifdef ROUND_HOLD_EN
        cnt_load  = 1'b0;
`endif
        if (menu) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (gs_play) begin
                        state_nxt = PLAY;
                    end
                end
                PLAY: begin
                    if (any_rise) begin
                        state_nxt = HOLD;
                    end else if (!gs_play) begin
                        state_nxt = IDLE;
                    end
                end
                HOLD: begin
                    if (hold_first) begin
                        // Scores updated last cycle; a win short-circuits the pause.
                        if (any_win) begin
                            state_nxt = OVER;
                            rr_nxt    = 1'b1;
                            win_set   = 1'b1;
                        end else begin
`ifdef ROUND_HOLD_EN
                            cnt_load = 1'b1;
`else
                            rr_nxt   = 1'b1;
`endif
                        end
                    end else begin
`ifdef ROUND_HOLD_EN
                        if (hold_cnt == '0) begin
                            rr_nxt    = 1'b1;
                            state_nxt = gs_play ? PLAY : IDLE;
                        end
`else
                        // Without the pause, the arena reset pulse is already out.
                        state_nxt = gs_play ? PLAY : IDLE;
`endif
                    end
                end
                OVER: begin
                    state_nxt = OVER;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Crash history, round-end marker, reset_round pulse and winner latch.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            crash_q     <= '0;
            hold_first  <= 1'b0;
            reset_round <= 1'b0;
            winner      <= '0;
        end else begin
            crash_q     <= menu ? '0 : crash;
            hold_first  <= round_end;
            reset_round <= rr_nxt;
            if (menu) begin
                winner <= '0;
            end else if (win_set) begin
                winner <= win_mask;
            end
        end
    end

`ifdef ROUND_HOLD_EN
    // Round-over pause down-counter, loaded once the winner check has passed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_cnt <= '0;
        end else if (menu) begin
            hold_cnt <= '0;
        end else if (cnt_load) begin
            hold_cnt <= HOLD_LOAD;
        end else if ((state == HOLD) && !hold_first && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_round_scoreboard.sv
// Directed bench for round_scoreboard: two-player and four-player instances share Game_State/Reset_n.
// Expected scores come from a per-player model and flow through a scoreboard queue.
// Outputs are sampled on the falling clock edge; inputs change right after sampling.
module tb_round_scoreboard;
    import tron_score_pkg::*;

    localparam int H = 4;
`ifdef ROUND_HOLD_EN
    localparam int P = 2 + H;   // reset_round cycle after the crash rise
    localparam int Q = 2 + H;   // PLAY resumes
`else
    localparam int P = 2;
    localparam int Q = 3;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [2:0] Game_State = 3'd0;
    logic [1:0] crash2 = '0;
    logic [3:0] crash4 = '0;

    logic [3:0] score2;
    logic       rr2, act2, mo2;
    logic [1:0] win2;
    logic [7:0] score4;
    logic       rr4, act4, mo4;
    logic [3:0] win4;

    int          errs = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    int          m2[2];
    int          m4[4];

    round_scoreboard #(.NUM_PLAYERS(2), .SCORE_W(2), .WIN_SCORE(3), .HOLD_CYCLES(H)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Game_State(Game_State), .crash(crash2),
        .score(score2), .reset_round(rr2), .round_active(act2), .winner(win2), .match_over(mo2)
    );

    round_scoreboard #(.NUM_PLAYERS(4), .SCORE_W(2), .WIN_SCORE(3), .HOLD_CYCLES(H)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .Game_State(Game_State), .crash(crash4),
        .score(score4), .reset_round(rr4), .round_active(act4), .winner(win4), .match_over(mo4)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int sel);
        logic [31:0] r;
        r = '0;
        if (sel != 0) begin
            for (int i = 0; i < 4; i++) r[i*2 +: 2] = 2'(m4[i]);
        end else begin
            for (int i = 0; i < 2; i++) r[i*2 +: 2] = 2'(m2[i]);
        end
        return r;
    endfunction

    function automatic logic [31:0] win_of(input int sel);
        logic [31:0] r;
        r = '0;
        if (sel != 0) begin
            for (int i = 0; i < 4; i++) r[i] = (m4[i] >= 3);
        end else begin
            for (int i = 0; i < 2; i++) r[i] = (m2[i] >= 3);
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m4[i] = 0;
        for (int i = 0; i < 2; i++) m2[i] = 0;
    endtask

    // Survivors gain a point (saturating at 3) unless every player crashed.
    task automatic apply_crash(input int sel, input logic [3:0] v, output logic [31:0] e);
        logic [3:0] allm;
        allm = (sel != 0) ? 4'hF : 4'h3;
        if ((v & allm) != allm) begin
            if (sel != 0) begin
                for (int i = 0; i < 4; i++) if (!v[i] && m4[i] < 3) m4[i]++;
            end else begin
                for (int i = 0; i < 2; i++) if (!v[i] && m2[i] < 3) m2[i]++;
            end
        end
        e = pack(sel);
    endtask

    function automatic logic [31:0] o_score(input int sel);
        return (sel != 0) ? 32'(score4) : 32'(score2);
    endfunction
    function automatic logic [31:0] o_rr(input int sel);
        return (sel != 0) ? 32'(rr4) : 32'(rr2);
    endfunction
    function automatic logic [31:0] o_act(input int sel);
        return (sel != 0) ? 32'(act4) : 32'(act2);
    endfunction
    function automatic logic [31:0] o_win(input int sel);
        return (sel != 0) ? 32'(win4) : 32'(win2);
    endfunction
    function automatic logic [31:0] o_mo(input int sel);
        return (sel != 0) ? 32'(mo4) : 32'(mo2);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_score2"}, 32'(score2), 0);
        chk({tag, "_score4"}, 32'(score4), 0);
        chk({tag, "_rr"},     32'({rr2, rr4}), 0);
        chk({tag, "_active"}, 32'({act2, act4}), 0);
        chk({tag, "_winner"}, 32'({win2, win4}), 0);
        chk({tag, "_over"},   32'({mo2, mo4}), 0);
    endtask

    // One crash round: drive v in cycle t, then follow the round to its end.
    task automatic play_round(input int sel, input logic [3:0] v, input bit keep);
        logic [31:0] e;
        logic        ew;
        int          first;
        int          np;
        @(negedge Clk);
        if (sel != 0) crash4 = v; else crash2 = v[1:0];
        apply_crash(sel, v, e);
        sb.push_back(e);
        ew = (win_of(sel) != 0);
        @(negedge Clk);
        if (!keep) begin
            crash2 = '0;
            crash4 = '0;
        end
        chk("score_t1", o_score(sel), sb.pop_front());
        chk("active_fall", o_act(sel), 0);
        if (ew) begin
            @(negedge Clk);
            chk("match_over", o_mo(sel), 1);
            chk("winner", o_win(sel), win_of(sel));
            chk("rr_win", o_rr(sel), 1);
            @(negedge Clk);
            chk("rr_win_once", o_rr(sel), 0);
            chk("match_hold", o_mo(sel), 1);
        end else begin
            first = -1;
            np = 0;
            for (int k = 2; k <= P + 2; k++) begin
                @(negedge Clk);
                if (o_rr(sel) != 0) begin
                    np++;
                    if (first < 0) first = k;
                end
                if (k == Q - 1) chk("hold_inactive", o_act(sel), 0);
            end
            chk("rr_cycle", 32'(first), 32'(P));
            chk("rr_count", 32'(np), 1);
            chk("resume_play", o_act(sel), 1);
        end
    endtask

    initial begin
        logic [31:0] e;
        int          np;
        clear_model();

        // Reset state
        repeat (2) @(negedge Clk);
        chk_all_zero("reset");

        // Leave reset, pass through menu, start play
        Reset_n = 1'b1;
        Game_State = GS_MENU;
        @(negedge Clk);
        Game_State = GS_PLAY;
        @(negedge Clk);
        chk("start_act2", 32'(act2), 1);
        chk("start_act4", 32'(act4), 1);

        // Two-player: player 1 crashes twice
        play_round(0, 4'b0010, 0);
        chk("p2_s0_1", 32'(score2), 32'h1);
        play_round(0, 4'b0010, 0);
        chk("p2_s0_2", 32'(score2), 32'h2);

        // Draw: no points, still one reset_round
        play_round(0, 4'b0011, 0);
        chk("draw_unchanged", 32'(score2), 32'h2);

        // Held crash: player 0 stays crashed across the hold
        play_round(0, 4'b0001, 1);
        repeat (3) @(negedge Clk);
        chk("held_no_point", 32'(score2), pack(0));
        chk("held_still_play", 32'(act2), 1);
        crash2 = '0;
        @(negedge Clk);
        play_round(0, 4'b0001, 0);
        chk("rearm_point", 32'(score2), 32'h8 | 32'h2);

        // Third win round for player 0
        play_round(0, 4'b0010, 0);
        chk("win_score", 32'(score2), 32'hB);
        chk("win_mask", 32'(win2), 32'h1);

        // OVER holds and ignores crashes
        repeat (3) @(negedge Clk);
        chk("over_hold", 32'(mo2), 1);
        crash2 = 2'b01;
        @(negedge Clk);
        crash2 = '0;
        repeat (2) @(negedge Clk);
        chk("over_score_held", 32'(score2), pack(0));
        chk("over_winner_held", 32'(win2), 32'h1);
        chk("over_no_rr", 32'(rr2), 0);

        // Menu clears the match
        Game_State = GS_MENU;
        @(negedge Clk);
        chk("menu_score", 32'(score2), 0);
        chk("menu_winner", 32'(win2), 0);
        chk("menu_over", 32'(mo2), 0);
        chk("menu_rr", 32'(rr2), 0);
        chk("menu_act", 32'(act2), 0);
        clear_model();
        Game_State = GS_PLAY;
        @(negedge Clk);
        chk("replay_act2", 32'(act2), 1);
        chk("replay_act4", 32'(act4), 1);

        // Four-player round: player 1 crashes
        play_round(1, 4'b0010, 0);
        chk("p4_const", 32'(score4), 32'h51);

        // Menu mid-hold
        @(negedge Clk);
        crash4 = 4'b0001;
        apply_crash(1, 4'b0001, e);
        sb.push_back(e);
        @(negedge Clk);
        crash4 = '0;
        chk("mh_score_t1", 32'(score4), sb.pop_front());
        Game_State = GS_MENU;
        @(negedge Clk);
        chk("mh_score_clr", 32'(score4), 0);
        chk("mh_act", 32'(act4), 0);
        chk("mh_rr", 32'(rr4), 0);
        clear_model();
        np = 0;
        repeat (P + 2) begin
            @(negedge Clk);
            if (rr4) np++;
        end
        chk("mh_no_pulse", 32'(np), 0);
        Game_State = GS_PLAY;
        @(negedge Clk);
        chk("mh_replay", 32'(act4), 1);

        // Asynchronous reset mid-round
        play_round(0, 4'b0010, 0);
        play_round(1, 4'b0100, 0);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all_zero("arst_round");
        clear_model();
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("arst_replay", 32'(act4), 1);

        // Asynchronous reset mid-hold: no pulse afterwards
        @(negedge Clk);
        crash4 = 4'b1000;
        apply_crash(1, 4'b1000, e);
        sb.push_back(e);
        @(negedge Clk);
        crash4 = '0;
        chk("ah_score_t1", 32'(score4), sb.pop_front());
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all_zero("arst_hold");
        clear_model();
        @(negedge Clk);
        Reset_n = 1'b1;
        np = 0;
        repeat (P + 2) begin
            @(negedge Clk);
            if (rr4) np++;
        end
        chk("ah_no_pulse", 32'(np), 0);
        chk("ah_replay", 32'(act4), 1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
